// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: shares one AXI4-lite SRAM slave between the instruction fetch unit (read-only)
// and the load/store unit (read and write).
//
// One transaction is granted at a time. The grant is held until that transaction's response
// handshake completes. A complete LSU write (AW and W both valid) wins over any read. Competing
// reads alternate between the two masters. After every response the arbiter spends one cycle in
// IDLE before it grants again.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   ifu_ar*/ifu_r*       IFU read address and read data channels
//   lsu_ar*/lsu_r*       LSU read address and read data channels
//   lsu_aw*/lsu_w*/lsu_b* LSU write address, write data and write response channels
//   s_*                  single AXI4-lite slave port towards the SRAM
// All outputs are combinational from the grant state plus the inputs. They are all zero in IDLE
// and while rst is high.
module axi_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // IFU
  input  logic                ifu_arvalid,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  // LSU
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  input  logic                lsu_awvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  output logic                lsu_awready,
  input  logic                lsu_wvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [1:0]          lsu_bresp,
  // Slave
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arready,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  output logic                s_awvalid,
  output logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awready,
  output logic                s_wvalid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wready,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp
);

  typedef enum logic [1:0] {StIdle, StIfuRd, StLsuRd, StLsuWr} state_e;

  state_e state_q, state_d;
  logic   last_rd_q, last_rd_d;  // last read served: 0 = IFU, 1 = LSU
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_rd_q <= 1'b1;  // IFU wins the first tie
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Grant decision and completion tracking
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      StIdle: begin
        // A lone AW does not win; it must not block reads while W is still missing
        if (lsu_awvalid && lsu_wvalid) begin
          state_d = StLsuWr;
        end else if (ifu_arvalid && lsu_arvalid) begin
          state_d = last_rd_q ? StIfuRd : StLsuRd;
        end else if (lsu_arvalid) begin
          state_d = StLsuRd;
        end else if (ifu_arvalid) begin
          state_d = StIfuRd;
        end
      end
      StIfuRd: begin
        if (s_rvalid && s_rready) begin
          state_d   = StIdle;
          last_rd_d = 1'b0;
        end
      end
      StLsuRd: begin
        if (s_rvalid && s_rready) begin
          state_d   = StIdle;
          last_rd_d = 1'b1;
        end
      end
      StLsuWr: begin
        if (s_awvalid && s_awready) aw_done_d = 1'b1;
        if (s_wvalid && s_wready)   w_done_d  = 1'b1;
        if (s_bvalid && s_bready) begin
          state_d   = StIdle;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Channel routing: only the granted master is connected, everyone else sees zeros
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_rready    = 1'b0;
    s_awvalid   = 1'b0;
    s_awaddr    = '0;
    s_wvalid    = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_bready    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIfuRd: begin
          s_arvalid   = ifu_arvalid;
          s_araddr    = ifu_araddr;
          ifu_arready = s_arready;
          s_rready    = ifu_rready;
          ifu_rvalid  = s_rvalid;
          ifu_rdata   = s_rdata;
          ifu_rresp   = s_rresp;
        end
        StLsuRd: begin
          s_arvalid   = lsu_arvalid;
          s_araddr    = lsu_araddr;
          lsu_arready = s_arready;
          s_rready    = lsu_rready;
          lsu_rvalid  = s_rvalid;
          lsu_rdata   = s_rdata;
          lsu_rresp   = s_rresp;
        end
        StLsuWr: begin
          // Each of AW and W handshakes exactly once, whichever completes first
          s_awvalid   = lsu_awvalid & ~aw_done_q;
          s_awaddr    = lsu_awaddr;
          lsu_awready = s_awready & ~aw_done_q;
          s_wvalid    = lsu_wvalid & ~w_done_q;
          s_wdata     = lsu_wdata;
          s_wstrb     = lsu_wstrb;
          lsu_wready  = s_wready & ~w_done_q;
          s_bready    = lsu_bready;
          lsu_bvalid  = s_bvalid;
          lsu_bresp   = s_bresp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: directed arbitration scenarios plus a randomized phase. A slave model
// answers with data derived from the address. Expected responses are queued per master at issue
// time and popped by an independent monitor whenever a response handshake is presented.
module tb_axi_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk, rst;
  logic          ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [AW-1:0] ifu_araddr;
  logic [DW-1:0] ifu_rdata;
  logic [1:0]    ifu_rresp;
  logic          lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic          lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
  logic [AW-1:0] lsu_araddr, lsu_awaddr;
  logic [DW-1:0] lsu_rdata, lsu_wdata;
  logic [SW-1:0] lsu_wstrb;
  logic [1:0]    lsu_rresp, lsu_bresp;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [1:0]    s_rresp, s_bresp;

  axi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arready(ifu_arready),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp),
    .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awready(lsu_awready),
    .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .lsu_bresp(lsu_bresp),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference rules ----------------
  // Slave content: address 0x80000000 holds 0x00000413; top nibble F is an error region.
  function automatic logic [31:0] rd_pattern(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ a ^ 32'h0000_0413;
  endfunction
  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (a[31:28] == 4'hF) ? 2'b10 : 2'b00;
  endfunction

  typedef struct {
    int          kind;  // 0 IFU read, 1 LSU read, 2 LSU write
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } exp_t;

  exp_t ifu_q[$];
  exp_t lsu_q[$];
  int   order_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   model_last_rd;  // last served reader, 1 = LSU

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur within bound at %0t", name, $time);
  endtask

  // ---------------- slave model ----------------
  typedef enum logic [1:0] {SlIdle, SlRdWait, SlRdResp, SlBResp} sl_e;
  sl_e         sl_st;
  int          sl_cnt, cur_ar, cur_aw, cur_w, cur_lat;
  logic        aw_got, w_got;
  logic [31:0] rd_addr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;
  bit          fix_dly = 1'b0;
  int          fix_ar = 0, fix_aw = 0, fix_w = 0, fix_lat = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sl_st <= SlIdle; sl_cnt <= 0;
      s_arready <= 1'b0; s_awready <= 1'b0; s_wready <= 1'b0;
      s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0; s_bvalid <= 1'b0; s_bresp <= '0;
      aw_got <= 1'b0; w_got <= 1'b0;
      cur_ar <= 0; cur_aw <= 0; cur_w <= 0; cur_lat <= 0;
    end else begin
      case (sl_st)
        SlIdle: begin
          if (s_arvalid) begin
            if (s_arready) begin
              rd_addr <= s_araddr; s_arready <= 1'b0; sl_cnt <= 0; sl_st <= SlRdWait;
            end else if (sl_cnt >= cur_ar) s_arready <= 1'b1;
            else sl_cnt <= sl_cnt + 1;
          end else if (s_awvalid || s_wvalid || aw_got || w_got) begin
            sl_cnt <= sl_cnt + 1;
            if (s_awvalid && s_awready) begin
              aw_got <= 1'b1; cap_awaddr <= s_awaddr; s_awready <= 1'b0;
            end else if (!aw_got && s_awvalid && sl_cnt >= cur_aw) s_awready <= 1'b1;
            if (s_wvalid && s_wready) begin
              w_got <= 1'b1; cap_wdata <= s_wdata; cap_wstrb <= s_wstrb; s_wready <= 1'b0;
            end else if (!w_got && s_wvalid && sl_cnt >= cur_w) s_wready <= 1'b1;
            if ((aw_got || (s_awvalid && s_awready)) && (w_got || (s_wvalid && s_wready))) begin
              s_bvalid <= 1'b1;
              s_bresp  <= resp_of(aw_got ? cap_awaddr : s_awaddr);
              sl_st    <= SlBResp;
            end
          end else begin
            sl_cnt  <= 0;
            cur_ar  <= fix_dly ? fix_ar  : int'($urandom_range(0, 2));
            cur_aw  <= fix_dly ? fix_aw  : int'($urandom_range(0, 3));
            cur_w   <= fix_dly ? fix_w   : int'($urandom_range(0, 3));
            cur_lat <= fix_dly ? fix_lat : int'($urandom_range(0, 3));
          end
        end
        SlRdWait: begin
          if (sl_cnt >= cur_lat) begin
            s_rvalid <= 1'b1; s_rdata <= rd_pattern(rd_addr); s_rresp <= resp_of(rd_addr);
            sl_st <= SlRdResp;
          end else sl_cnt <= sl_cnt + 1;
        end
        SlRdResp: begin
          if (s_rready) begin
            s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0; sl_cnt <= 0; sl_st <= SlIdle;
          end
        end
        default: begin
          if (s_bready) begin
            s_bvalid <= 1'b0; s_bresp <= '0; aw_got <= 1'b0; w_got <= 1'b0;
            sl_cnt <= 0; sl_st <= SlIdle;
          end
        end
      endcase
    end
  end

  // ---------------- response readiness ----------------
  initial begin
    ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ifu_rready = ($urandom_range(0, 3) != 0);
      lsu_rready = ($urandom_range(0, 3) != 0);
      lsu_bready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int aw_hs = 0, w_hs = 0;
  bit aw_extra = 1'b0, w_extra = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_hs = 0; w_hs = 0; aw_extra = 1'b0; w_extra = 1'b0;
      end else begin
        if (s_awvalid && aw_hs > 0) aw_extra = 1'b1;
        if (s_wvalid && w_hs > 0) w_extra = 1'b1;
        if (s_awvalid && s_awready) aw_hs++;
        if (s_wvalid && s_wready) w_hs++;
        if (ifu_rvalid && ifu_rready) begin
          if (ifu_q.size() == 0) fail_now("ifu_unexpected_resp");
          else begin
            e = ifu_q.pop_front();
            chk("ifu_rdata", ifu_rdata, e.data);
            chk("ifu_rresp", ifu_rresp, e.resp);
            chk("ifu_resp_isolated", {lsu_rvalid, lsu_bvalid}, 0);
            order_q.push_back(0);
            model_last_rd = 1'b0;
          end
        end
        if (lsu_rvalid && lsu_rready) begin
          if (lsu_q.size() == 0) fail_now("lsu_unexpected_rresp");
          else begin
            e = lsu_q.pop_front();
            chk("lsu_r_kind", 1, e.kind);
            chk("lsu_rdata", lsu_rdata, e.data);
            chk("lsu_rresp", lsu_rresp, e.resp);
            chk("lsu_resp_isolated", ifu_rvalid, 0);
            order_q.push_back(1);
            model_last_rd = 1'b1;
          end
        end
        if (lsu_bvalid && lsu_bready) begin
          if (lsu_q.size() == 0) fail_now("lsu_unexpected_bresp");
          else begin
            e = lsu_q.pop_front();
            chk("lsu_b_kind", 2, e.kind);
            chk("lsu_bresp", lsu_bresp, e.resp);
            chk("wr_payload", {cap_awaddr, cap_wdata}, {e.addr, e.data});
            chk("wr_strb", cap_wstrb, e.strb);
            chk("aw_once", {aw_extra, aw_hs[7:0]}, {1'b0, 8'd1});
            chk("w_once", {w_extra, w_hs[7:0]}, {1'b0, 8'd1});
            chk("wr_ifu_stalled", ifu_rvalid, 0);
            order_q.push_back(2);
          end
          aw_hs = 0; w_hs = 0; aw_extra = 1'b0; w_extra = 1'b0;
        end
      end
    end
  end

  // ---------------- master drivers ----------------
  task automatic wait_empty(input bit who);
    int n = 0;
    while ((who ? lsu_q.size() : ifu_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if ((who ? lsu_q.size() : ifu_q.size()) != 0) begin
      fail_now(who ? "lsu_resp_timeout" : "ifu_resp_timeout");
      if (who) lsu_q.delete(); else ifu_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic start_read(input bit who, input logic [31:0] a);
    exp_t e;
    e.kind = who ? 1 : 0; e.addr = a; e.data = rd_pattern(a); e.strb = '0; e.resp = resp_of(a);
    if (who) begin
      lsu_q.push_back(e); lsu_arvalid = 1'b1; lsu_araddr = a;
    end else begin
      ifu_q.push_back(e); ifu_arvalid = 1'b1; ifu_araddr = a;
    end
  endtask

  task automatic finish_read(input bit who);
    int n = 0;
    bit hs = 1'b0;
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = who ? (lsu_arvalid && lsu_arready) : (ifu_arvalid && ifu_arready);
      n++;
    end
    @(posedge clk); #1;
    if (who) begin lsu_arvalid = 1'b0; lsu_araddr = '0; end
    else begin ifu_arvalid = 1'b0; ifu_araddr = '0; end
    if (!hs) fail_now(who ? "lsu_ar_timeout" : "ifu_ar_timeout");
    wait_empty(who);
  endtask

  task automatic do_read(input bit who, input logic [31:0] a);
    start_read(who, a);
    finish_read(who);
  endtask

  task automatic lsu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lag);
    exp_t e;
    bit awd = 1'b0, wd = 1'b0, ah, wh;
    int n = 0;
    e.kind = 2; e.addr = a; e.data = d; e.strb = s; e.resp = resp_of(a);
    lsu_q.push_back(e);
    lsu_awvalid = 1'b1; lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s;
    if (lag == 0) lsu_wvalid = 1'b1;
    while (!(awd && wd) && n < 300) begin
      @(negedge clk);
      ah = lsu_awvalid && lsu_awready;
      wh = lsu_wvalid && lsu_wready;
      @(posedge clk); #1;
      n++;
      if (ah) begin lsu_awvalid = 1'b0; awd = 1'b1; end
      if (wh) begin lsu_wvalid = 1'b0; wd = 1'b1; end
      if (!wd && n >= lag) lsu_wvalid = 1'b1;
    end
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    if (!(awd && wd)) fail_now("lsu_aw_w_timeout");
    wait_empty(1'b1);
  endtask

  task automatic check_order(input string name, input int exp_o[$]);
    chk({name, "_count"}, order_q.size(), exp_o.size());
    for (int i = 0; i < exp_o.size() && i < order_q.size(); i++) chk(name, order_q[i], exp_o[i]);
    order_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    ifu_q.delete(); lsu_q.delete(); order_q.delete();
    model_last_rd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int eo[$];
    int first;
    logic any_out;
    ifu_araddr = '0; lsu_araddr = '0; lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0;
    do_reset();

    // Reset state: everything quiet
    chk("reset_idle_outputs", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                               ifu_rvalid, lsu_rvalid, lsu_bvalid}, 0);

    // IFU only, with grant latency check, then the mandatory idle cycle before the next grant
    start_read(1'b0, 32'h8000_0000);
    @(negedge clk);
    chk("idle_no_forward", {s_arvalid, ifu_arready}, 0);
    @(negedge clk);
    chk("grant_latency_arvalid", s_arvalid, 1);
    chk("grant_araddr", s_araddr, 32'h8000_0000);
    finish_read(1'b0);
    start_read(1'b1, 32'h8000_2000);
    @(negedge clk);
    chk("idle_after_resp", {s_arvalid, lsu_arready}, 0);
    @(negedge clk);
    chk("lsu_grant_arvalid", {s_arvalid, ifu_arready}, 2'b10);
    finish_read(1'b1);
    eo = {0, 1};
    check_order("ifu_only_order", eo);

    // Read contention after reset: alternate starting with IFU
    do_reset();
    first = model_last_rd ? 0 : 1;
    fork
      begin for (int i = 0; i < 4; i++) do_read(1'b0, 32'h8000_0100 + 32'(4 * i)); end
      begin for (int i = 0; i < 4; i++) do_read(1'b1, 32'h8000_3000 + 32'(4 * i)); end
    join
    eo = {};
    for (int i = 0; i < 8; i++) eo.push_back((i % 2 == 0) ? first : 1 - first);
    check_order("contention_order", eo);

    // Write beats a simultaneous read
    fork
      lsu_write(32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 0);
      do_read(1'b0, 32'h8000_0040);
    join
    eo = {2, 0};
    check_order("write_over_read_order", eo);

    // A lone AW does not block a read; the write follows once W shows up
    fork
      lsu_write(32'h8000_1004, 32'h1234_5678, 4'h3, 2);
      do_read(1'b0, 32'h8000_0044);
    join
    eo = {0, 2};
    check_order("lone_aw_order", eo);

    // Split handshakes: AW accepted two cycles ahead of W
    fix_dly = 1'b1; fix_ar = 0; fix_aw = 0; fix_w = 2; fix_lat = 1;
    @(posedge clk); #1;
    lsu_write(32'h8000_1008, 32'hCAFE_F00D, 4'hC, 0);
    fix_dly = 1'b0;

    // Error pass-through on an LSU read, and on a write
    do_read(1'b1, 32'hF000_0010);
    lsu_write(32'hF000_0020, 32'h0BAD_0BAD, 4'h1, 1);
    order_q.delete();

    // Randomized mix
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1 do_read(1'b0, ($urandom_range(0, 7) == 0) ? 32'hF000_0000 | 32'($urandom_range(0, 255))
                                                         : 32'h8000_0000 | 32'($urandom));
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          if ($urandom_range(0, 1) == 0)
            do_read(1'b1, ($urandom_range(0, 5) == 0) ? 32'hF000_0100 : 32'($urandom));
          else
            lsu_write(($urandom_range(0, 5) == 0) ? 32'hF000_0200 : 32'($urandom), $urandom,
                      4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
        end
      end
    join
    order_q.delete();

    // Reset in the middle of an IFU read
    fix_dly = 1'b1; fix_ar = 0; fix_aw = 0; fix_w = 0; fix_lat = 8;
    @(posedge clk); #1;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0800;
    begin
      int n = 0;
      while (!s_arvalid && n < 20) begin @(negedge clk); n++; end
      if (!s_arvalid) fail_now("midread_grant");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    any_out = |{ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp, lsu_arready, lsu_rvalid,
                lsu_rdata, lsu_rresp, lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
                s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr, s_wvalid, s_wdata,
                s_wstrb, s_bready};
    chk("midread_reset_outputs_zero", any_out, 0);
    ifu_arvalid = 1'b0;
    fix_dly = 1'b0;
    do_reset();
    fork
      do_read(1'b0, 32'h8000_0900);
      do_read(1'b1, 32'h8000_4000);
    join
    eo = {0, 1};
    check_order("post_reset_tie", eo);

    chk("no_pending_responses", ifu_q.size() + lsu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Shares one AXI4-lite SRAM slave port between two masters: the instruction fetch unit (read-only) and the load/store unit (read and write).
- Sits between the IFU/LSU handshake ports and the single memory instance.
- Grants exactly one transaction at a time and holds the grant until that transaction's response handshake completes.
- Arbitration: an LSU write beats any read; competing reads alternate round-robin.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- ifu_arvalid, ifu_rready  in  1  IFU read address valid; IFU read data ready.
- ifu_araddr  in  ADDR_W  IFU read address.
- ifu_arready, ifu_rvalid  out  1  forwarded to IFU when IFU is granted.
- ifu_rdata  out  DATA_W  read data to IFU.
- ifu_rresp  out  2  read response to IFU.
- lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready  in  1  LSU channel valids/readies.
- lsu_araddr, lsu_awaddr  in  ADDR_W  LSU read/write addresses.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_wstrb  in  DATA_W/8  LSU byte strobes.
- lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid  out  1  forwarded to LSU when granted.
- lsu_rdata  out  DATA_W  read data to LSU.
- lsu_rresp, lsu_bresp  out  2  read/write responses to LSU.
- s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready  out  1  to SRAM slave.
- s_araddr, s_awaddr  out  ADDR_W  to slave.
- s_wdata  out  DATA_W  to slave.
- s_wstrb  out  DATA_W/8  to slave.
- s_arready, s_rvalid, s_awready, s_wready, s_bvalid  in  1  from slave.
- s_rdata  in  DATA_W  from slave.
- s_rresp, s_bresp  in  2  from slave.

Behaviour:
- States: IDLE, IFU_RD, LSU_RD, LSU_WR. Registered regs: state, last_rd (0=IFU, 1=LSU), aw_done, w_done.
- Reset (async, rst=1): state=IDLE, last_rd=1 (so IFU wins the first tie), aw_done=w_done=0.
- All outputs are combinational from state plus inputs. In IDLE and during reset every valid/ready output and every data/addr/resp output is 0.
- IDLE transitions, evaluated each cycle:
  - lsu_awvalid & lsu_wvalid -> LSU_WR.
  - else both read requests present -> grant the side not equal to last_rd.
  - else lsu_arvalid -> LSU_RD; else ifu_arvalid -> IFU_RD; else stay in IDLE.
- A write needs both aw and w valid to win. An lone lsu_awvalid waits and does not block reads.
- Grant latency: request sampled in IDLE at cycle N; slave sees the forwarded valid in cycle N+1. No masters see ready in IDLE.
- IFU_RD / LSU_RD:
  - Granted master's AR and R channels are wired straight to the slave (valid, addr, ready, data, resp). Non-granted master sees all zeros.
  - Exit to IDLE on the cycle s_rvalid & s_rready. That cycle, set last_rd = granted side.
- LSU_WR:
  - AW and W are forwarded independently. aw_done is set on s_awvalid&s_awready; w_done is set on s_wvalid&s_wready.
  - s_awvalid = lsu_awvalid & !aw_done; s_wvalid = lsu_wvalid & !w_done. Each channel handshakes once.
  - B is forwarded to the LSU. On s_bvalid & s_bready: return to IDLE and clear aw_done/w_done.
  - The IFU is fully stalled for the whole write.
- Back-to-back: after a response, one IDLE cycle always precedes the next grant. Minimum period is 1 cycle of arbitration plus the slave latency.
- Responses pass through unmodified, including SLVERR 2'b10.
- Only the granted master's response is forwarded, so a response cannot reach the wrong master.
- Masters must hold valid until ready (AXI rule). If valid drops while granted, the grant is held until the response completes.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The slave is reset by the same rst, so no stale response survives.
- Simultaneous response completion and a new request: the new request is not granted in that cycle. It is arbitrated on the following IDLE cycle.

Test Plan:
- IFU only: ifu_arvalid=1, araddr=0x80000000; slave returns rdata=0x00000413 -> s_arvalid high from cycle 1; ifu_rvalid/ifu_rdata=0x00000413; lsu_rvalid stays 0; state back to IDLE.
- Read contention after reset: both arvalid=1 in the same cycle -> IFU served first, then LSU. Repeat with both still asserted -> grants alternate IFU, LSU, IFU, LSU.
- Write over read: lsu_awvalid=lsu_wvalid=1, awaddr=0x80001000, wdata=0xDEADBEEF, wstrb=4'hF, plus ifu_arvalid=1 -> write completes first (lsu_bvalid, bresp=0); IFU is granted only after that.
- Split write handshakes: slave asserts awready 2 cycles before wready -> s_awvalid drops after its handshake; s_wvalid persists until wready; exactly one AW and one W handshake occur.
- Error pass-through: slave returns rresp=2'b10 on an LSU read -> lsu_rresp=2'b10; IFU outputs unaffected.
- Reset mid-read: assert rst while in IFU_RD before s_rvalid -> all outputs 0 in the same cycle. After release, a new ifu_arvalid is granted normally with IFU-first tie priority.
